// File: rtl/thor2025_regfile_wrqueue.sv
// thor2025_regfile_wrqueue: write-back queue in front of the 3-write/10-read register file.
// Takes up to two committed results per cycle, keeps them in age order and drains up to three
// per cycle onto regfile write ports 0..2, oldest on port 0. The regfile gives the highest
// numbered port priority, so the youngest write to a register wins.
// Optional feature macro: THOR2025_WBQ_PEND_EN adds pend_ra/pend_hit, a pending-write lookup.
module thor2025_regfile_wrqueue #(
    parameter int WID  = 64,
    parameter int RBIT = 11,
    parameter int DEP  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_v0,
    input  logic [RBIT:0]   in_a0,
    input  logic [7:0]      in_we0,
    input  logic [WID-1:0]  in_d0,
    input  logic            in_v1,
    input  logic [RBIT:0]   in_a1,
    input  logic [7:0]      in_we1,
    input  logic [WID-1:0]  in_d1,
    output logic            in_rdy,
    input  logic            hold,
    output logic            wr0,
    output logic            wr1,
    output logic            wr2,
    output logic [RBIT:0]   wa0,
    output logic [RBIT:0]   wa1,
    output logic [RBIT:0]   wa2,
    output logic [7:0]      we0,
    output logic [7:0]      we1,
    output logic [7:0]      we2,
    output logic [WID-1:0]  i0,
    output logic [WID-1:0]  i1,
    output logic [WID-1:0]  i2,
`ifdef THOR2025_WBQ_PEND_EN
    input  logic [RBIT:0]   pend_ra,
    output logic            pend_hit,
`endif
    output logic            empty
);

    localparam int PW = $clog2(DEP);
    localparam int CW = PW + 1;

    logic [RBIT:0]  mem_a [DEP];
    logic [7:0]     mem_we[DEP];
    logic [WID-1:0] mem_d [DEP];

    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic           out_wr[3];
    logic [RBIT:0]  out_a [3];
    logic [7:0]     out_we[3];
    logic [WID-1:0] out_d [3];

    logic           acc0;
    logic           acc1;
    logic [1:0]     n_in;
    logic [1:0]     n_out;

    // Admission and drain sizing for this cycle, all from registered state.
    always_comb begin
        in_rdy = (CW'(DEP) - count) >= CW'(2);
        acc0   = in_v0 && in_rdy && (in_we0 != 8'h00);
        acc1   = in_v1 && in_rdy && (in_we1 != 8'h00);
        n_in   = {1'b0, acc0} + {1'b0, acc1};
        if (hold)
            n_out = 2'd0;
        else if (count >= CW'(3))
            n_out = 2'd3;
        else
            n_out = count[1:0];
    end

    // Storage array: accepted results land in free slots in arrival order; no reset needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (acc0) begin
                mem_a[wr_ptr]  <= in_a0;
                mem_we[wr_ptr] <= in_we0;
                mem_d[wr_ptr]  <= in_d0;
            end
            if (acc1) begin
                mem_a[wr_ptr + PW'(acc0)]  <= in_a1;
                mem_we[wr_ptr + PW'(acc0)] <= in_we1;
                mem_d[wr_ptr + PW'(acc0)]  <= in_d1;
            end
        end
    end

    // Pointers and occupancy; the free-slot check in in_rdy keeps count at or below DEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_in);
            rd_ptr <= rd_ptr + PW'(n_out);
            count  <= count + CW'(n_in) - CW'(n_out);
        end
    end

    // Output stage: load the oldest entries onto ports 0..2; unused ports and hold keep data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                out_wr[k] <= 1'b0;
                out_a[k]  <= '0;
                out_we[k] <= '0;
                out_d[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                out_wr[k] <= (k < int'(n_out));
                if (k < int'(n_out)) begin
                    out_a[k]  <= mem_a[rd_ptr + PW'(k)];
                    out_we[k] <= mem_we[rd_ptr + PW'(k)];
                    out_d[k]  <= mem_d[rd_ptr + PW'(k)];
                end
            end
        end
    end

    assign wr0 = out_wr[0];
    assign wr1 = out_wr[1];
    assign wr2 = out_wr[2];
    assign wa0 = out_a[0];
    assign wa1 = out_a[1];
    assign wa2 = out_a[2];
    assign we0 = out_we[0];
    assign we1 = out_we[1];
    assign we2 = out_we[2];
    assign i0  = out_d[0];
    assign i1  = out_d[1];
    assign i2  = out_d[2];

    assign empty = (count == '0) && !out_wr[0] && !out_wr[1] && !out_wr[2];

`ifdef THOR2025_WBQ_PEND_EN
    logic [PW-1:0] offs;

    // Pending-write lookup over occupied slots and live output ports; forced low in reset.
    always_comb begin
        pend_hit = 1'b0;
        offs     = '0;
        for (int s = 0; s < DEP; s++) begin
            offs = PW'(s) - rd_ptr;
            if ((CW'(offs) < count) && (mem_a[s] == pend_ra))
                pend_hit = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            if (out_wr[k] && (out_a[k] == pend_ra))
                pend_hit = 1'b1;
        end
        if (rst)
            pend_hit = 1'b0;
    end
`endif

    // Producers must not present results while the queue is not ready.
    assert property (@(posedge clk) disable iff (rst) !((in_v0 || in_v1) && !in_rdy));

endmodule

// File: tb/tb_thor2025_regfile_wrqueue.sv
// tb_thor2025_regfile_wrqueue: directed self-checking bench for thor2025_regfile_wrqueue.
// Covers THOR2025_WBQ_PEND_EN when that macro is defined for both files.
module tb_thor2025_regfile_wrqueue;

    logic        clk;
    logic        rst;
    logic        in_v0, in_v1;
    logic [11:0] in_a0, in_a1;
    logic [7:0]  in_we0, in_we1;
    logic [63:0] in_d0, in_d1;
    logic        in_rdy;
    logic        hold;
    logic        wr0, wr1, wr2;
    logic [11:0] wa0, wa1, wa2;
    logic [7:0]  we0, we1, we2;
    logic [63:0] i0, i1, i2;
    logic        empty;
`ifdef THOR2025_WBQ_PEND_EN
    logic [11:0] pend_ra;
    logic        pend_hit;
`endif

    int checks;
    int passes;

    thor2025_regfile_wrqueue dut (
        .clk(clk), .rst(rst),
        .in_v0(in_v0), .in_a0(in_a0), .in_we0(in_we0), .in_d0(in_d0),
        .in_v1(in_v1), .in_a1(in_a1), .in_we1(in_we1), .in_d1(in_d1),
        .in_rdy(in_rdy), .hold(hold),
        .wr0(wr0), .wr1(wr1), .wr2(wr2),
        .wa0(wa0), .wa1(wa1), .wa2(wa2),
        .we0(we0), .we1(we1), .we2(we2),
        .i0(i0), .i1(i1), .i2(i2),
`ifdef THOR2025_WBQ_PEND_EN
        .pend_ra(pend_ra), .pend_hit(pend_hit),
`endif
        .empty(empty)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic v0, input logic [11:0] a0, input logic [7:0] e0,
                                 input logic [63:0] d0, input logic v1, input logic [11:0] a1,
                                 input logic [7:0] e1, input logic [63:0] d1);
        in_v0 = v0; in_a0 = a0; in_we0 = e0; in_d0 = d0;
        in_v1 = v1; in_a1 = a1; in_we1 = e1; in_d1 = d1;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 12'd0, 8'h00, 64'd0, 1'b0, 12'd0, 8'h00, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; every check is sampled 1 time unit after a rising edge.
    initial begin
        checks = 0;
        passes = 0;
        rst  = 1'b1;
        hold = 1'b0;
`ifdef THOR2025_WBQ_PEND_EN
        pend_ra = 12'd0;
`endif
        clearInputs();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("idle_wr",     {61'd0, wr0, wr1, wr2}, 64'd0);
        checkOutput("idle_rdy",    64'(in_rdy), 64'd1);
        checkOutput("idle_empty",  64'(empty), 64'd1);
        checkOutput("idle_count",  64'(dut.count), 64'd0);

        // Pair of results, two-cycle latency to the write ports.
        applyStimulus(1'b1, 12'd5, 8'hFF, 64'h11, 1'b1, 12'd6, 8'h0F, 64'h22);
        tick();
        clearInputs();
        checkOutput("pair_count",  64'(dut.count), 64'd2);
        checkOutput("pair_early",  {61'd0, wr0, wr1, wr2}, 64'd0);
        tick();
        checkOutput("pair_wr",     {61'd0, wr0, wr1, wr2}, 64'b110);
        checkOutput("pair_wa0",    64'(wa0), 64'd5);
        checkOutput("pair_i0",     i0, 64'h11);
        checkOutput("pair_we0",    64'(we0), 64'hFF);
        checkOutput("pair_wa1",    64'(wa1), 64'd6);
        checkOutput("pair_we1",    64'(we1), 64'h0F);
        checkOutput("pair_i1",     i1, 64'h22);
        tick();
        checkOutput("pair_done",   64'(empty), 64'd1);

        // Fill under hold: 2 per cycle for 4 cycles.
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 12'(16 + 2 * k), 8'hFF, 64'(100 + 2 * k),
                          1'b1, 12'(17 + 2 * k), 8'hFF, 64'(101 + 2 * k));
            tick();
            clearInputs();
            if (k == 2) begin
                checkOutput("fill3_count", 64'(dut.count), 64'd6);
                checkOutput("fill3_rdy",   64'(in_rdy), 64'd1);
            end
        end
        checkOutput("fill_count",  64'(dut.count), 64'd8);
        checkOutput("fill_rdy",    64'(in_rdy), 64'd0);
        checkOutput("hold_wr",     {61'd0, wr0, wr1, wr2}, 64'd0);
        checkOutput("hold_wa0",    64'(wa0), 64'd5);
        hold = 1'b0;
        tick();
        checkOutput("dr1_wr",      {61'd0, wr0, wr1, wr2}, 64'b111);
        checkOutput("dr1_wa",      {28'd0, wa0, wa1, wa2}, {28'd0, 12'd16, 12'd17, 12'd18});
        checkOutput("dr1_i2",      i2, 64'd102);
        tick();
        checkOutput("dr2_wr",      {61'd0, wr0, wr1, wr2}, 64'b111);
        checkOutput("dr2_wa",      {28'd0, wa0, wa1, wa2}, {28'd0, 12'd19, 12'd20, 12'd21});
        tick();
        checkOutput("dr3_wr",      {61'd0, wr0, wr1, wr2}, 64'b110);
        checkOutput("dr3_wa",      {40'd0, wa0, wa1}, {40'd0, 12'd22, 12'd23});
        checkOutput("dr3_i1",      i1, 64'd107);
        tick();
        checkOutput("dr_empty",    64'(empty), 64'd1);
        checkOutput("dr_wr",       {61'd0, wr0, wr1, wr2}, 64'd0);

        // Same register written twice in one cycle: younger lands on the higher port.
        applyStimulus(1'b1, 12'd9, 8'hFF, 64'hA, 1'b1, 12'd9, 8'hFF, 64'hB);
        tick();
        clearInputs();
        tick();
        checkOutput("same_wa",     {40'd0, wa0, wa1}, {40'd0, 12'd9, 12'd9});
        checkOutput("same_i0",     i0, 64'hA);
        checkOutput("same_i1",     i1, 64'hB);
        checkOutput("same_rf9",    (wr2 && wa2 == 12'd9) ? i2 :
                                   (wr1 && wa1 == 12'd9) ? i1 : i0, 64'hB);
        tick();

        // Zero byte enables are dropped.
        applyStimulus(1'b1, 12'd3, 8'h00, 64'h33, 1'b0, 12'd0, 8'h00, 64'd0);
        tick();
        clearInputs();
        checkOutput("we0_count",   64'(dut.count), 64'd0);
        tick();
        checkOutput("we0_wr",      {61'd0, wr0, wr1, wr2}, 64'd0);

        // Lone younger result takes port 0.
        applyStimulus(1'b0, 12'd0, 8'h00, 64'd0, 1'b1, 12'd7, 8'h3C, 64'h77);
        tick();
        clearInputs();
        tick();
        checkOutput("solo_wr",     {61'd0, wr0, wr1, wr2}, 64'b100);
        checkOutput("solo_wa0",    64'(wa0), 64'd7);
        checkOutput("solo_i0",     i0, 64'h77);
        tick();

        // Five entries queued under hold, then reset mid-operation.
        hold = 1'b1;
        applyStimulus(1'b1, 12'd40, 8'hFF, 64'd1, 1'b1, 12'd41, 8'hFF, 64'd2);
        tick();
        applyStimulus(1'b1, 12'd42, 8'hFF, 64'd3, 1'b1, 12'd43, 8'hFF, 64'd4);
        tick();
        applyStimulus(1'b0, 12'd0, 8'h00, 64'd0, 1'b1, 12'd44, 8'hFF, 64'd5);
        tick();
        clearInputs();
        checkOutput("five_count",  64'(dut.count), 64'd5);
`ifdef THOR2025_WBQ_PEND_EN
        pend_ra = 12'd44;
        #1;
        checkOutput("pend_hit",    64'(pend_hit), 64'd1);
        pend_ra = 12'd45;
        #1;
        checkOutput("pend_miss",   64'(pend_hit), 64'd0);
        pend_ra = 12'd44;
`endif
        hold = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_count",   64'(dut.count), 64'd0);
        checkOutput("rst_wr",      {61'd0, wr0, wr1, wr2}, 64'd0);
`ifdef THOR2025_WBQ_PEND_EN
        checkOutput("rst_pend",    64'(pend_hit), 64'd0);
`endif
        rst = 1'b0;
        tick();
        checkOutput("rst_empty",   64'(empty), 64'd1);
        checkOutput("rst_rdy",     64'(in_rdy), 64'd1);
`ifdef THOR2025_WBQ_PEND_EN
        checkOutput("pend_clear",  64'(pend_hit), 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
